// File: rtl/bank_biu_linefill_ctrl_if.sv
// -----------------------------------------------------------------------------
// bank_biu_linefill_ctrl_if
//
// Bundles every non-clock/reset signal of the bank linefill engine:
//   - lf_req_*     : linefill request channel (engine is the receiver)
//   - axi_ar*      : memory read-address channel (engine is the master)
//   - axi_r*       : memory read-data channel (engine is the receiver)
//   - biu_isu_r*   : assembled-line channel to the ISU (engine is the sender)
//   - lf_outstanding_o / lf_err_o : status outputs
//
// Modports:
//   master : the linefill engine's view (drives every *_o signal)
//   slave  : the surrounding environment's view (request source, memory, ISU)
// -----------------------------------------------------------------------------
interface bank_biu_linefill_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 3
);
    // Linefill request channel
    logic              lf_req_valid_i;
    logic              lf_req_ready_o;
    logic [2:0]        lf_req_set_i;
    logic [2:0]        lf_req_way_i;
    logic [ADDR_W-1:0] lf_req_addr_i;

    // Memory read-address channel
    logic              axi_arvalid_o;
    logic              axi_arready_i;
    logic [ADDR_W-1:0] axi_araddr_o;
    logic [5:0]        axi_arid_o;
    logic [7:0]        axi_arlen_o;
    logic [2:0]        axi_arsize_o;
    logic [1:0]        axi_arburst_o;

    // Memory read-data channel
    logic              axi_rvalid_i;
    logic              axi_rready_o;
    logic [DATA_W-1:0] axi_rdata_i;
    logic [5:0]        axi_rid_i;
    logic [1:0]        axi_rresp_i;
    logic              axi_rlast_i;

    // Assembled-line channel to the ISU
    logic              biu_isu_rvalid_o;
    logic              biu_isu_rready_i;
    logic [255:0]      biu_isu_rdata_o;
    logic [5:0]        biu_isu_rid_o;

    // Status
    logic [CNT_W-1:0]  lf_outstanding_o;
    logic              lf_err_o;

    modport master (
        input  lf_req_valid_i, lf_req_set_i, lf_req_way_i, lf_req_addr_i,
        output lf_req_ready_o,
        output axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o,
               axi_arsize_o, axi_arburst_o,
        input  axi_arready_i,
        input  axi_rvalid_i, axi_rdata_i, axi_rid_i, axi_rresp_i, axi_rlast_i,
        output axi_rready_o,
        output biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o,
        input  biu_isu_rready_i,
        output lf_outstanding_o, lf_err_o
    );

    modport slave (
        output lf_req_valid_i, lf_req_set_i, lf_req_way_i, lf_req_addr_i,
        input  lf_req_ready_o,
        input  axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o,
               axi_arsize_o, axi_arburst_o,
        output axi_arready_i,
        output axi_rvalid_i, axi_rdata_i, axi_rid_i, axi_rresp_i, axi_rlast_i,
        input  axi_rready_o,
        input  biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o,
        output biu_isu_rready_i,
        input  lf_outstanding_o, lf_err_o
    );
endinterface

// File: rtl/bank_biu_linefill_ctrl.sv
// -----------------------------------------------------------------------------
// bank_biu_linefill_ctrl
//
// Linefill read engine for one cache bank. Each accepted request becomes one
// single-burst read on the memory AR channel (arid = {set, way}); the returned
// beats are assembled into a 256-bit line which is then offered to the ISU on
// the biu_isu_r* channel, tagged with the burst's ID.
//
// Ports:
//   clk_i  : single clock
//   rst_i  : asynchronous, active-low reset
//   bus    : bank_biu_linefill_ctrl_if.master
//            lf_req_*   request in  (ready = AR slot free and not full)
//            axi_ar*    one INCR burst of BEATS beats per request
//            axi_r*     beat return, bursts not interleaved
//            biu_isu_r* assembled line out, held until consumed
//            lf_outstanding_o : linefills issued on AR and not yet delivered
//            lf_err_o         : sticky protocol/response error
//
// Parameters:
//   DATA_W : beat width, 64/128/256 (BEATS = 256/DATA_W)
//   ADDR_W : byte address width
//   MAX_OS : maximum outstanding linefills, 1..8
// -----------------------------------------------------------------------------
module bank_biu_linefill_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int MAX_OS = 4,
    localparam int BEATS = 256 / DATA_W,
    localparam int CNT_W = $clog2(MAX_OS + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    bank_biu_linefill_ctrl_if.master     bus
);

    // Beat counter is at least one bit wide so it can be declared; with a
    // single-beat burst it simply never leaves 0.
    localparam int                  BCNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCNT_W-1:0]   LAST_BEAT = BCNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]    OS_MAX    = CNT_W'(MAX_OS);
    localparam logic [7:0]          AR_LEN    = 8'(BEATS - 1);
    localparam logic [2:0]          AR_SIZE   = 3'($clog2(DATA_W / 8));
    localparam logic [1:0]          AR_INCR   = 2'b01;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // AR stage: single request slot
    logic                  ar_valid_q;
    logic [ADDR_W-1:0]     araddr_q;
    logic [5:0]            arid_q;

    // Linefills issued on AR and not yet handed to the ISU
    logic [CNT_W-1:0]      os_cnt;

    // Beat assembly
    logic [BCNT_W-1:0]     bcnt;
    logic [5:0]            burst_id_q;
    logic [255:0]          asm_q;

    // Output line register
    logic                  out_valid_q;
    logic [255:0]          line_q;
    logic [5:0]            line_id_q;

    logic                  err_q;

    // ------------------------------------------------------------------------
    // Handshakes and beat classification
    // ------------------------------------------------------------------------
    logic                  req_ready;
    logic                  req_hs;
    logic                  ar_hs;
    logic                  r_ready;
    logic                  r_hs;
    logic                  out_hs;
    logic                  at_last;
    logic                  completes;
    logic [5:0]            beat_id;
    logic [255:0]          merged_line;
    logic                  beat_err;
    logic                  os_err;

    assign req_ready = ~ar_valid_q & (os_cnt < OS_MAX);
    assign req_hs    = bus.lf_req_valid_i & req_ready;
    assign ar_hs     = ar_valid_q & bus.axi_arready_i;
    assign out_hs    = out_valid_q & bus.biu_isu_rready_i;

    // A beat ends the line either because memory says so (rlast) or because
    // the line is full; in the latter case a missing rlast is an error but the
    // counter still wraps and the line is delivered.
    assign at_last   = (bcnt == LAST_BEAT);
    assign completes = bus.axi_rlast_i | at_last;

    // Only the line-completing beat needs the output register, so earlier
    // beats keep flowing into the assembly buffer while a line is held.
    assign r_ready   = ~out_valid_q | bus.biu_isu_rready_i | ~completes;
    assign r_hs      = bus.axi_rvalid_i & r_ready;

    // The first beat defines the burst ID; a single-beat burst takes it
    // directly from the bus.
    assign beat_id   = (bcnt == '0) ? bus.axi_rid_i : burst_id_q;

    // Assembly buffer with the current beat merged in, so the final beat lands
    // in the output line in the same cycle it is accepted.
    // NOTE: combinational blocks assign a full default first so no path leaves
    // a bit unassigned, which would otherwise infer a latch.
    always_comb begin
        merged_line = asm_q;
        merged_line[int'(bcnt) * DATA_W +: DATA_W] = bus.axi_rdata_i;
    end

    assign beat_err = r_hs & ( (bus.axi_rresp_i != 2'b00)
                             | (bus.axi_rlast_i & ~at_last)
                             | (at_last & ~bus.axi_rlast_i)
                             | ((bcnt != '0) & (bus.axi_rid_i != burst_id_q)) );

    // Delivering a line that was never issued cannot be accounted for.
    assign os_err   = out_hs & (os_cnt == '0);

    // ------------------------------------------------------------------------
    // AR stage
    // ------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // sample the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ar_valid_q <= 1'b0;
            araddr_q   <= '0;
            arid_q     <= '0;
        end else if (req_hs) begin
            // req_ready already excludes a pending AR, so capture cannot
            // disturb a payload that memory has not yet taken.
            ar_valid_q <= 1'b1;
            araddr_q   <= {bus.lf_req_addr_i[ADDR_W-1:5], 5'b0};
            arid_q     <= {bus.lf_req_set_i, bus.lf_req_way_i};
        end else if (ar_hs) begin
            ar_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outstanding counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            os_cnt <= '0;
        end else begin
            case ({ar_hs, out_hs})
                2'b10: if (os_cnt != OS_MAX) os_cnt <= os_cnt + 1'b1;
                2'b01: if (os_cnt != '0)     os_cnt <= os_cnt - 1'b1;
                default: ;  // idle, or issue and delivery cancel out
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Beat assembly
    // ------------------------------------------------------------------------
    // NOTE: the line-wide data registers are reset as well so that nothing
    // from before a reset can surface in a later line or on the output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bcnt       <= '0;
            burst_id_q <= '0;
            asm_q      <= '0;
        end else if (r_hs) begin
            asm_q <= merged_line;
            if (bcnt == '0) begin
                burst_id_q <= bus.axi_rid_i;
            end
            bcnt <= completes ? '0 : bcnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output line register
    // ------------------------------------------------------------------------
    // A completing beat takes priority over clearing: when the ISU consumes
    // the held line in the same cycle, the new line replaces it with no bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_q <= 1'b0;
            line_q      <= '0;
            line_id_q   <= '0;
        end else if (r_hs && completes) begin
            out_valid_q <= 1'b1;
            line_q      <= merged_line;
            line_id_q   <= beat_id;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (beat_err || os_err) begin
            err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.lf_req_ready_o   = req_ready;

    assign bus.axi_arvalid_o    = ar_valid_q;
    assign bus.axi_araddr_o     = araddr_q;
    assign bus.axi_arid_o       = arid_q;
    assign bus.axi_arlen_o      = AR_LEN;
    assign bus.axi_arsize_o     = AR_SIZE;
    assign bus.axi_arburst_o    = AR_INCR;

    assign bus.axi_rready_o     = r_ready;

    assign bus.biu_isu_rvalid_o = out_valid_q;
    assign bus.biu_isu_rdata_o  = line_q;
    assign bus.biu_isu_rid_o    = line_id_q;

    assign bus.lf_outstanding_o = os_cnt;
    assign bus.lf_err_o         = err_q;

endmodule

// File: tb/tb_bank_biu_linefill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bank_biu_linefill_ctrl
//
// Directed and randomized stimulus for bank_biu_linefill_ctrl. A transaction
// level reference (queues of pending AR requests and delivered lines, an array
// of beat slots, an outstanding count and an error flag) is advanced from the
// handshakes seen on the bus and compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_bank_biu_linefill_ctrl;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int MAX_OS = 4;
    localparam int BEATS  = 256 / DATA_W;
    localparam int CNT_W  = $clog2(MAX_OS + 1);
    localparam int BOUND  = 50;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    bank_biu_linefill_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    bank_biu_linefill_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MAX_OS (MAX_OS)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [5:0]        id;
    } ar_t;

    typedef struct {
        logic [255:0] data;
        logic [5:0]   id;
    } line_t;

    ar_t               m_ar[$];     // accepted requests not yet taken by memory
    line_t             m_line[$];   // completed lines not yet taken by the ISU
    logic [DATA_W-1:0] m_slot[BEATS];
    int                m_beat;
    logic [5:0]        m_first_id;
    int                m_os;
    bit                m_err;

    function automatic void model_reset();
        m_ar.delete();
        m_line.delete();
        for (int k = 0; k < BEATS; k++) m_slot[k] = '0;
        m_beat     = 0;
        m_first_id = '0;
        m_os       = 0;
        m_err      = 1'b0;
    endfunction

    function automatic logic [255:0] model_line();
        logic [255:0] l;
        for (int k = 0; k < BEATS; k++) l[k*DATA_W +: DATA_W] = m_slot[k];
        return l;
    endfunction

    // Mid-cycle monitor: inputs are stable, DUT state reflects the last edge.
    always @(negedge clk_i) begin
        bit req_hs, ar_hs, r_hs, out_hs, final_beat;
        if (!rst_i) begin
            model_reset();
        end else begin
            final_beat = bus.axi_rlast_i || (m_beat == BEATS - 1);

            check("mon_outstanding", bus.lf_outstanding_o, m_os);
            check("mon_err",         bus.lf_err_o,         m_err);
            check("mon_arvalid",     bus.axi_arvalid_o,    m_ar.size() != 0);
            check("mon_req_ready",   bus.lf_req_ready_o,   (m_ar.size() == 0) && (m_os < MAX_OS));
            check("mon_rvalid",      bus.biu_isu_rvalid_o, m_line.size() != 0);
            check("mon_rready",      bus.axi_rready_o,
                  (m_line.size() == 0) || bus.biu_isu_rready_i || !final_beat);
            if (m_ar.size() != 0) begin
                check("mon_araddr", bus.axi_araddr_o, m_ar[0].addr);
                check("mon_arid",   bus.axi_arid_o,   m_ar[0].id);
            end
            if (m_line.size() != 0) begin
                check("mon_line_data", bus.biu_isu_rdata_o, m_line[0].data);
                check("mon_line_id",   bus.biu_isu_rid_o,   m_line[0].id);
            end

            req_hs = bus.lf_req_valid_i && bus.lf_req_ready_o;
            ar_hs  = bus.axi_arvalid_o && bus.axi_arready_i;
            r_hs   = bus.axi_rvalid_i && bus.axi_rready_o;
            out_hs = bus.biu_isu_rvalid_o && bus.biu_isu_rready_i;

            if (ar_hs && m_ar.size() != 0) void'(m_ar.pop_front());
            if (req_hs) m_ar.push_back('{addr: {bus.lf_req_addr_i[ADDR_W-1:5], 5'b0},
                                         id:   {bus.lf_req_set_i, bus.lf_req_way_i}});

            if (out_hs && m_os == 0) m_err = 1'b1;
            if (ar_hs && !out_hs && m_os < MAX_OS) m_os++;
            if (out_hs && !ar_hs && m_os > 0) m_os--;
            if (out_hs && m_line.size() != 0) void'(m_line.pop_front());

            if (r_hs) begin
                if (bus.axi_rresp_i != 2'b00) m_err = 1'b1;
                if (bus.axi_rlast_i != (m_beat == BEATS - 1)) m_err = 1'b1;
                if (m_beat != 0 && bus.axi_rid_i != m_first_id) m_err = 1'b1;
                if (m_beat == 0) m_first_id = bus.axi_rid_i;
                m_slot[m_beat] = bus.axi_rdata_i;
                if (final_beat) begin
                    m_line.push_back('{data: model_line(), id: m_first_id});
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------------
    logic [5:0] ids[$];

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic send_req(input logic [2:0] s, input logic [2:0] w, input logic [ADDR_W-1:0] a);
        int n = 0;
        bus.lf_req_valid_i = 1'b1;
        bus.lf_req_set_i   = s;
        bus.lf_req_way_i   = w;
        bus.lf_req_addr_i  = a;
        #1;
        while (!bus.lf_req_ready_o && n < BOUND) begin tick(); #1; n++; end
        check("req_accept_bound", n < BOUND, 1'b1);
        tick();
        bus.lf_req_valid_i = 1'b0;
        ids.push_back({s, w});
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [5:0] id,
                             input logic [1:0] resp, input logic last);
        int n = 0;
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rdata_i  = d;
        bus.axi_rid_i    = id;
        bus.axi_rresp_i  = resp;
        bus.axi_rlast_i  = last;
        #1;
        while (!bus.axi_rready_o && n < BOUND) begin tick(); #1; n++; end
        check("beat_accept_bound", n < BOUND, 1'b1);
        tick();
        bus.axi_rvalid_i = 1'b0;
        bus.axi_rlast_i  = 1'b0;
        bus.axi_rresp_i  = 2'b00;
    endtask

    task automatic send_burst(input logic [5:0] id, input int nbeats, input int bad_beat);
        for (int k = 0; k < nbeats; k++)
            send_beat({$urandom, $urandom}, id, (k == bad_beat) ? 2'b10 : 2'b00, k == nbeats - 1);
    endtask

    task automatic take_line(input int delay);
        int n = 0;
        for (int k = 0; k < delay; k++) tick();
        bus.biu_isu_rready_i = 1'b1;
        #1;
        while (!bus.biu_isu_rvalid_o && n < BOUND) begin tick(); #1; n++; end
        check("line_ready_bound", n < BOUND, 1'b1);
        tick();
        bus.biu_isu_rready_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_arvalid"},  bus.axi_arvalid_o,    1'b0);
        check({phase, "_rvalid"},   bus.biu_isu_rvalid_o, 1'b0);
        check({phase, "_os"},       bus.lf_outstanding_o, 0);
        check({phase, "_rready"},   bus.axi_rready_o,     1'b1);
        check({phase, "_reqready"}, bus.lf_req_ready_o,   1'b1);
        check({phase, "_err"},      bus.lf_err_o,         1'b0);
        check({phase, "_rdata"},    bus.biu_isu_rdata_o,  256'd0);
        check({phase, "_rid"},      bus.biu_isu_rid_o,    6'd0);
    endtask

    // Global guard against a hung run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Directed sequence followed by a randomized phase
    // ------------------------------------------------------------------------
    initial begin
        logic [5:0] id_a, id_b;
        int         n;

        bus.lf_req_valid_i   = 1'b0;
        bus.lf_req_set_i     = '0;
        bus.lf_req_way_i     = '0;
        bus.lf_req_addr_i    = '0;
        bus.axi_arready_i    = 1'b1;
        bus.axi_rvalid_i     = 1'b0;
        bus.axi_rdata_i      = '0;
        bus.axi_rid_i        = '0;
        bus.axi_rresp_i      = '0;
        bus.axi_rlast_i      = 1'b0;
        bus.biu_isu_rready_i = 1'b0;

        // Reset values
        tick(); tick();
        #1;
        check_reset_outputs("reset");
        rst_i = 1'b1;
        tick();

        // First request: AR fields one cycle after the request handshake
        send_req(3'd3, 3'd5, 32'h1234_5678);
        #1;
        check("ar_valid_next",  bus.axi_arvalid_o, 1'b1);
        check("ar_addr",        bus.axi_araddr_o,  32'h1234_5660);
        check("ar_id",          bus.axi_arid_o,    6'h1D);
        check("ar_len",         bus.axi_arlen_o,   8'd3);
        check("ar_size",        bus.axi_arsize_o,  3'd3);
        check("ar_burst",       bus.axi_arburst_o, 2'd1);
        check("req_ready_ar",   bus.lf_req_ready_o, 1'b0);
        tick(); #1;
        check("os_after_ar",    bus.lf_outstanding_o, 1);

        // Directed burst and line assembly
        void'(ids.pop_front());
        send_beat(64'h0000_0000_0000_0000, 6'h1D, 2'b00, 1'b0);
        send_beat(64'h1111_1111_1111_1111, 6'h1D, 2'b00, 1'b0);
        send_beat(64'h2222_2222_2222_2222, 6'h1D, 2'b00, 1'b0);
        send_beat(64'h3333_3333_3333_3333, 6'h1D, 2'b00, 1'b1);
        #1;
        check("line_valid_next", bus.biu_isu_rvalid_o, 1'b1);
        check("line_data",       bus.biu_isu_rdata_o,
              {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
               64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000});
        check("line_id",         bus.biu_isu_rid_o, 6'h1D);
        take_line(0);
        #1;
        check("os_after_line",   bus.lf_outstanding_o, 0);
        check("rvalid_cleared",  bus.biu_isu_rvalid_o, 1'b0);

        // Full: MAX_OS outstanding blocks further requests
        for (int k = 0; k < MAX_OS; k++)
            send_req(3'($urandom), 3'($urandom), $urandom);
        bus.lf_req_valid_i = 1'b1;
        bus.lf_req_set_i   = 3'd7;
        bus.lf_req_way_i   = 3'd1;
        bus.lf_req_addr_i  = 32'hCAFE_0040;
        tick(); tick(); #1;
        check("full_os",        bus.lf_outstanding_o, MAX_OS);
        check("full_req_ready", bus.lf_req_ready_o,   1'b0);
        send_burst(ids.pop_front(), BEATS, -1);
        take_line(0);
        #1;
        check("ready_after_free", bus.lf_req_ready_o, 1'b1);
        tick();
        bus.lf_req_valid_i = 1'b0;
        ids.push_back({3'd7, 3'd1});
        for (int k = 0; k < MAX_OS; k++) begin
            send_burst(ids.pop_front(), BEATS, -1);
            take_line($urandom_range(0, 2));
        end
        #1;
        check("drained_os", bus.lf_outstanding_o, 0);

        // Back-pressure: second burst's final beat waits for the held line
        send_req(3'd1, 3'd2, $urandom);
        send_req(3'd4, 3'd6, $urandom);
        id_a = ids.pop_front();
        id_b = ids.pop_front();
        send_burst(id_a, BEATS, -1);
        for (int k = 0; k < BEATS - 1; k++)
            send_beat({$urandom, $urandom}, id_b, 2'b00, 1'b0);
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rdata_i  = {$urandom, $urandom};
        bus.axi_rid_i    = id_b;
        bus.axi_rlast_i  = 1'b1;
        #1;
        check("bp_rready_low",   bus.axi_rready_o, 1'b0);
        tick(); #1;
        check("bp_rready_held",  bus.axi_rready_o, 1'b0);
        check("bp_line_a_id",    bus.biu_isu_rid_o, id_a);
        bus.biu_isu_rready_i = 1'b1;
        #1;
        check("bp_rready_open",  bus.axi_rready_o, 1'b1);
        tick();
        bus.axi_rvalid_i     = 1'b0;
        bus.axi_rlast_i      = 1'b0;
        bus.biu_isu_rready_i = 1'b0;
        #1;
        check("bp_no_bubble",    bus.biu_isu_rvalid_o, 1'b1);
        check("bp_line_b_id",    bus.biu_isu_rid_o, id_b);
        take_line(0);

        // Errors: bad response, then a short burst; both lines delivered
        send_req(3'd2, 3'd2, $urandom);
        send_req(3'd5, 3'd0, $urandom);
        send_burst(ids.pop_front(), BEATS, 1);
        #1;
        check("err_rresp",       bus.lf_err_o, 1'b1);
        take_line(0);
        send_burst(ids.pop_front(), 3, -1);
        #1;
        check("short_line_valid", bus.biu_isu_rvalid_o, 1'b1);
        take_line(1);
        tick(); #1;
        check("err_sticky",      bus.lf_err_o, 1'b1);
        check("err_os",          bus.lf_outstanding_o, 0);

        // Reset with beat 2 of a burst pending
        send_req(3'd6, 3'd3, $urandom);
        send_beat({$urandom, $urandom}, ids[0], 2'b00, 1'b0);
        send_beat({$urandom, $urandom}, ids[0], 2'b00, 1'b0);
        bus.axi_rvalid_i = 1'b1;
        bus.axi_rdata_i  = {$urandom, $urandom};
        #1;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick(); tick();
        bus.axi_rvalid_i = 1'b0;
        ids.delete();
        rst_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            check("post_rst_rvalid", bus.biu_isu_rvalid_o, 1'b0);
        end

        // Randomized phase
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, MAX_OS);
            for (int k = 0; k < n; k++)
                send_req(3'($urandom), 3'($urandom), $urandom);
            for (int k = 0; k < n; k++) begin
                send_burst(ids.pop_front(), BEATS, -1);
                take_line($urandom_range(0, 3));
            end
        end
        tick(); #1;
        check("final_os",  bus.lf_outstanding_o, 0);
        check("final_err", bus.lf_err_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
